// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and helpers for the two-master, split-capable
// system bus arbiter (bus_arbiter and its picker arb_pick).
package bus_arb_pkg;

   localparam int NUM_MASTERS = 2;

   // Index of one of the two masters.
   typedef logic master_idx_t;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      RESUME = 2'd2
   } arb_state_t;

   // One-hot master line for a master index.
   function automatic logic [NUM_MASTERS-1:0] master_onehot(input master_idx_t m);
      return (m == 1'b1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational two-way picker. Takes the mask of eligible masters
// and returns the winner plus a valid flag.
// With BUS_ARB_ROUND_ROBIN_EN defined, a tie goes to the master named by the
// pointer input; otherwise master 0 always wins a tie and no pointer exists.
module arb_pick
   import bus_arb_pkg::*;
(
   input  logic [NUM_MASTERS-1:0] eligible,
`ifdef BUS_ARB_ROUND_ROBIN_EN
   input  master_idx_t            ptr,
`endif
   output master_idx_t            winner,
   output logic                   valid
);

   // Pick one eligible master; a tie is resolved by the build's policy
   always_comb begin
      winner = 1'b0;
      valid  = |eligible;
      case (eligible)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
         2'b11:   winner = ptr;
`else
         2'b11:   winner = 1'b0;
`endif
         default: winner = 1'b0;
      endcase
   end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: central arbiter for the serial system bus. Shares the bus
// between two masters and sequences a single outstanding split transaction:
// a splitting slave parks the owning master, the bus is handed to the other
// master, and the parked master is later resumed with split_grant to the
// slave that split.
// Optional feature macro: BUS_ARB_ROUND_ROBIN_EN (round-robin tie break);
// undefined gives fixed priority with master 0 winning ties.
// Every output is a registered decode of the current state, so each output
// changes one clock after the state transition that causes it.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NUM_SLAVES = 3,
   parameter int SIDX_WIDTH = 2
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] mbreq,
   input  logic [NUM_SLAVES-1:0]  ssplit,
   output logic [NUM_MASTERS-1:0] mgrant,
   output logic                   bus_owner,
   output logic [NUM_MASTERS-1:0] msplit,
   output logic [NUM_SLAVES-1:0]  split_grant,
   output logic                   split_err
);

   arb_state_t              state_r, state_s;
   master_idx_t             owner_r, owner_s;
   logic                    sp_valid_r, sp_valid_s;
   master_idx_t             sp_master_r, sp_master_s;
   logic [SIDX_WIDTH-1:0]   sp_slave_r, sp_slave_s;
   logic [NUM_SLAVES-1:0]   ssplit_q_r;

   logic [NUM_SLAVES-1:0]   rise_s;
   logic                    rise_any_s;
   logic [SIDX_WIDTH-1:0]   rise_idx_s;
   logic                    sp_pending_s;
   logic [NUM_MASTERS-1:0]  parked_s;
   logic [NUM_MASTERS-1:0]  eligible_s;
   master_idx_t             pick_winner_s;
   logic                    pick_valid_s;
   logic                    err_set_s;

   logic [NUM_MASTERS-1:0]  mgrant_r, mgrant_s;
   logic                    bus_owner_r, bus_owner_s;
   logic [NUM_MASTERS-1:0]  msplit_r, msplit_s;
   logic [NUM_SLAVES-1:0]   split_grant_r, split_grant_s;
   logic                    split_err_r, split_err_s;

`ifdef BUS_ARB_ROUND_ROBIN_EN
   master_idx_t             ptr_r, ptr_s;
`endif

   // Split edge detect, lowest rising slave, and the recorded slave's flag
   always_comb begin
      rise_s       = ssplit & ~ssplit_q_r;
      rise_any_s   = |rise_s;
      rise_idx_s   = {SIDX_WIDTH{1'b0}};
      sp_pending_s = 1'b0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         rise_idx_s   = rise_s[i] ? i[SIDX_WIDTH-1:0] : rise_idx_s;
         sp_pending_s = (sp_slave_r == i[SIDX_WIDTH-1:0]) ? ssplit[i] : sp_pending_s;
      end
   end

   // A parked master stays masked out of arbitration until its resume starts
   always_comb begin
      if (sp_valid_r && (state_r != RESUME)) begin
         parked_s = master_onehot(sp_master_r);
      end else begin
         parked_s = 2'b00;
      end
      eligible_s = mbreq & ~parked_s;
   end

   arb_pick u_pick (
      .eligible (eligible_s),
`ifdef BUS_ARB_ROUND_ROBIN_EN
      .ptr      (ptr_r),
`endif
      .winner   (pick_winner_s),
      .valid    (pick_valid_s)
   );

   // Next-state logic: arbitration, split recording and resume sequencing
   always_comb begin
      state_s     = state_r;
      owner_s     = owner_r;
      sp_valid_s  = sp_valid_r;
      sp_master_s = sp_master_r;
      sp_slave_s  = sp_slave_r;
      err_set_s   = 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      ptr_s       = ptr_r;
`endif
      case (state_r)
         IDLE: begin
            if (sp_valid_r && !sp_pending_s) begin
               state_s = RESUME;
            end else if (pick_valid_s) begin
               state_s = GRANT;
               owner_s = pick_winner_s;
`ifdef BUS_ARB_ROUND_ROBIN_EN
               ptr_s   = ~pick_winner_s;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         GRANT: begin
            // A dropped request wins over a split arriving on the same edge
            if (!mbreq[owner_r]) begin
               state_s = IDLE;
            end else if (rise_any_s && !sp_valid_r) begin
               state_s     = IDLE;
               sp_valid_s  = 1'b1;
               sp_master_s = owner_r;
               sp_slave_s  = rise_idx_s;
            end else begin
               state_s = GRANT;
            end
            // Only one split may be outstanding; a second one is an error
            if (rise_any_s && sp_valid_r) begin
               err_set_s = 1'b1;
            end else begin
               err_set_s = 1'b0;
            end
         end
         RESUME: begin
            if (!mbreq[sp_master_r]) begin
               state_s    = IDLE;
               sp_valid_s = 1'b0;
            end else begin
               state_s = RESUME;
            end
         end
         default: begin
            state_s    = IDLE;
            sp_valid_s = 1'b0;
         end
      endcase
   end

   // State, split record and split-flag history registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         owner_r     <= 1'b0;
         sp_valid_r  <= 1'b0;
         sp_master_r <= 1'b0;
         sp_slave_r  <= {SIDX_WIDTH{1'b0}};
         ssplit_q_r  <= {NUM_SLAVES{1'b0}};
      end else begin
         state_r     <= state_s;
         owner_r     <= owner_s;
         sp_valid_r  <= sp_valid_s;
         sp_master_r <= sp_master_s;
         sp_slave_r  <= sp_slave_s;
         ssplit_q_r  <= ssplit;
      end
   end

`ifdef BUS_ARB_ROUND_ROBIN_EN
   // Round-robin pointer: names the master that wins the next tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r <= 1'b0;
      end else begin
         ptr_r <= ptr_s;
      end
   end
`endif

   // Output decode from the current state; bus_owner holds while idle
   always_comb begin
      mgrant_s      = 2'b00;
      bus_owner_s   = bus_owner_r;
      split_grant_s = {NUM_SLAVES{1'b0}};
      msplit_s      = parked_s;
      split_err_s   = split_err_r | err_set_s;
      case (state_r)
         GRANT: begin
            mgrant_s    = master_onehot(owner_r);
            bus_owner_s = owner_r;
         end
         RESUME: begin
            mgrant_s    = master_onehot(sp_master_r);
            bus_owner_s = sp_master_r;
            for (int i = 0; i < NUM_SLAVES; i++) begin
               split_grant_s[i] = (sp_slave_r == i[SIDX_WIDTH-1:0]);
            end
         end
         default: begin
            mgrant_s = 2'b00;
         end
      endcase
   end

   // Output registers; reset drops every grant immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mgrant_r      <= 2'b00;
         bus_owner_r   <= 1'b0;
         msplit_r      <= 2'b00;
         split_grant_r <= {NUM_SLAVES{1'b0}};
         split_err_r   <= 1'b0;
      end else begin
         mgrant_r      <= mgrant_s;
         bus_owner_r   <= bus_owner_s;
         msplit_r      <= msplit_s;
         split_grant_r <= split_grant_s;
         split_err_r   <= split_err_s;
      end
   end

   assign mgrant      = mgrant_r;
   assign bus_owner   = bus_owner_r;
   assign msplit      = msplit_r;
   assign split_grant = split_grant_r;
   assign split_err   = split_err_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized checks of bus_arbiter against a
// transaction-level model of arbitration order and fixed output latencies.
// Tie-break expectations follow BUS_ARB_ROUND_ROBIN_EN when it is defined.
module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mbreq;
   logic [2:0] ssplit;
   logic [1:0] mgrant;
   logic       bus_owner;
   logic [1:0] msplit;
   logic [2:0] split_grant;
   logic       split_err;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Model state: the master that wins the next tie (round-robin build only)
   logic rr_next = 1'b0;

   bus_arbiter #(.NUM_SLAVES(3), .SIDX_WIDTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .mbreq       (mbreq),
      .ssplit      (ssplit),
      .mgrant      (mgrant),
      .bus_owner   (bus_owner),
      .msplit      (msplit),
      .split_grant (split_grant),
      .split_err   (split_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] oh(input logic m);
      return m ? 2'b10 : 2'b01;
   endfunction

   // Model of one arbitration: who wins among the requesting masters
   task automatic model_grant(input logic [1:0] elig, output logic w);
`ifdef BUS_ARB_ROUND_ROBIN_EN
      if (elig == 2'b11) w = rr_next;
      else               w = elig[0] ? 1'b0 : 1'b1;
`else
      w = elig[0] ? 1'b0 : 1'b1;
`endif
      rr_next = ~w;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mgrant"},      8'(mgrant),      8'h00);
      chk({tag, "_owner"},       8'(bus_owner),   8'h00);
      chk({tag, "_msplit"},      8'(msplit),      8'h00);
      chk({tag, "_split_grant"}, 8'(split_grant), 8'h00);
      chk({tag, "_split_err"},   8'(split_err),   8'h00);
   endtask

   initial begin
      logic w;
      logic [1:0] req;
      int hold;

      // Reset
      rst = 1'b1; mbreq = 2'b00; ssplit = 3'b000;
      tick; tick;
      chk_all_zero("reset");
      rst = 1'b0;
      tick;
      chk_all_zero("post_reset");

      // Single request: grant two edges after the request, drop two after release
      mbreq = 2'b01; model_grant(2'b01, w);
      tick; chk("single_latency", 8'(mgrant), 8'h00);
      tick; chk("single_grant", 8'(mgrant), 8'(oh(w)));
      chk("single_owner", 8'(bus_owner), 8'(w));
      tick; tick; tick;
      mbreq = 2'b00;
      tick; chk("single_hold", 8'(mgrant), 8'h01);
      tick; chk("single_release", 8'(mgrant), 8'h00);
      tick;

      // Contention: both request for three transactions, one idle gap each
      mbreq = 2'b11; model_grant(2'b11, w);
      tick; tick;
      chk("cont_grant0", 8'(mgrant), 8'(oh(w)));
      for (int t = 1; t < 3; t++) begin
         mbreq = 2'b11 & ~oh(w);
         tick;
         mbreq = 2'b11; model_grant(2'b11, w);
         tick; chk("cont_gap", 8'(mgrant), 8'h00);
         tick; chk("cont_grant", 8'(mgrant), 8'(oh(w)));
         chk("cont_owner", 8'(bus_owner), 8'(w));
      end
      mbreq = 2'b00;
      tick; tick; chk("cont_release", 8'(mgrant), 8'h00);

      // Split: master 0 parked by slave 2, master 1 served, then resume
      mbreq = 2'b01; model_grant(2'b01, w);
      tick; tick; chk("split_pre_grant", 8'(mgrant), 8'h01);
      mbreq = 2'b11; ssplit = 3'b100;
      tick;
      model_grant(2'b10, w);
      tick; chk("split_mgrant_off", 8'(mgrant), 8'h00);
      chk("split_msplit", 8'(msplit), 8'h01);
      tick; chk("split_other_grant", 8'(mgrant), 8'h02);
      chk("split_other_owner", 8'(bus_owner), 8'h01);
      mbreq = 2'b01;
      tick; tick; chk("split_idle", 8'(mgrant), 8'h00);
      tick; tick; chk("split_parked_ignored", 8'(mgrant), 8'h00);
      chk("split_still_parked", 8'(msplit), 8'h01);
      ssplit = 3'b000;
      tick;
      tick; chk("resume_mgrant", 8'(mgrant), 8'h01);
      chk("resume_split_grant", 8'(split_grant), 8'h04);
      chk("resume_msplit", 8'(msplit), 8'h00);
      chk("resume_owner", 8'(bus_owner), 8'h00);
      mbreq = 2'b00;
      tick; tick; chk("resume_end_mgrant", 8'(mgrant), 8'h00);
      chk("resume_end_sg", 8'(split_grant), 8'h00);

      // Resume priority over a new request from master 1
      mbreq = 2'b01; model_grant(2'b01, w);
      tick; tick; chk("prio_pre_grant", 8'(mgrant), 8'h01);
      ssplit = 3'b010;
      tick; tick; chk("prio_parked", 8'(msplit), 8'h01);
      mbreq = 2'b11; ssplit = 3'b000;
      tick;
      tick; chk("prio_resume_first", 8'(mgrant), 8'h01);
      chk("prio_split_grant", 8'(split_grant), 8'h02);
      tick; tick; chk("prio_m1_waits", 8'(mgrant), 8'h01);
      mbreq = 2'b10; model_grant(2'b10, w);
      tick; tick; chk("prio_gap", 8'(mgrant), 8'h00);
      tick; chk("prio_m1_grant", 8'(mgrant), 8'h02);
      mbreq = 2'b00;
      tick; tick;

      // Double split: second rise while one split is outstanding
      mbreq = 2'b01; model_grant(2'b01, w);
      tick; tick;
      mbreq = 2'b11; ssplit = 3'b001;
      tick;
      model_grant(2'b10, w);
      tick; chk("dbl_err_clear", 8'(split_err), 8'h00);
      tick; chk("dbl_m1_grant", 8'(mgrant), 8'h02);
      ssplit = 3'b011;
      tick; tick;
      chk("dbl_err_set", 8'(split_err), 8'h01);
      chk("dbl_grant_kept", 8'(mgrant), 8'h02);
      chk("dbl_msplit", 8'(msplit), 8'h01);
      mbreq = 2'b01; ssplit = 3'b010;
      tick; tick; tick;
      chk("dbl_resume", 8'(mgrant), 8'h01);
      chk("dbl_resume_sg", 8'(split_grant), 8'h01);
      mbreq = 2'b00;
      tick; tick;
      chk("dbl_no_record", 8'(msplit), 8'h00);
      chk("dbl_err_sticky", 8'(split_err), 8'h01);
      ssplit = 3'b000;
      tick; tick;
      chk("dbl_no_second_resume", 8'(split_grant), 8'h00);

      // Randomized request transactions against the arbitration model
      for (int t = 0; t < 24; t++) begin
         req = 2'($urandom_range(1, 3));
         mbreq = req; model_grant(req, w);
         tick; chk("rnd_latency", 8'(mgrant), 8'h00);
         tick; chk("rnd_grant", 8'(mgrant), 8'(oh(w)));
         chk("rnd_owner", 8'(bus_owner), 8'(w));
         hold = int'($urandom_range(0, 3));
         repeat (hold) tick;
         chk("rnd_hold", 8'(mgrant), 8'(oh(w)));
         mbreq = 2'b00;
         tick; tick; chk("rnd_release", 8'(mgrant), 8'h00);
      end

      // Async reset in the middle of a resume
      mbreq = 2'b10; model_grant(2'b10, w);
      tick; tick; chk("rst_pre_grant", 8'(mgrant), 8'h02);
      ssplit = 3'b100;
      tick; tick; chk("rst_parked", 8'(msplit), 8'h02);
      ssplit = 3'b000;
      tick; tick; chk("rst_resume", 8'(mgrant), 8'h02);
      chk("rst_resume_sg", 8'(split_grant), 8'h04);
      #2 rst = 1'b1;
      #1 chk("async_mgrant", 8'(mgrant), 8'h00);
      chk("async_sg", 8'(split_grant), 8'h00);
      chk("async_msplit", 8'(msplit), 8'h00);
      chk("async_err", 8'(split_err), 8'h00);
      rr_next = 1'b0;
      tick;
      rst = 1'b0;
      mbreq = 2'b10; model_grant(2'b10, w);
      tick; chk("post_rst_latency", 8'(mgrant), 8'h00);
      tick; chk("post_rst_grant", 8'(mgrant), 8'h02);
      chk("post_rst_msplit", 8'(msplit), 8'h00);
      mbreq = 2'b00;
      tick; tick;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
